// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with start-glitch filter, parity/framing checks,
// idle/end-of-packet detection and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int IDLE_BITS  = 16
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            rxd,
    input  logic                            rd_en,
    output logic [DATA_BITS-1:0]            rd_data,
    output logic                            rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overrun,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            rx_idle,
    output logic                            rx_endofpacket
);
    localparam int DIV_RAW  = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W   = $clog2(OVERSAMPLE);
    localparam int BIT_W    = $clog2(DATA_BITS + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = $clog2(FIFO_DEPTH + 1);
    localparam int IDLE_MAX = IDLE_BITS * OVERSAMPLE;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t                r_state;
    logic [1:0]            r_sync;
    logic                  r_rx_prev;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_bad;
    logic                  r_push;
    logic                  r_frame_err;
    logic                  r_parity_err;
    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overrun;
    logic [IDLE_W-1:0]     r_idle_cnt;
    logic                  r_idle_d;
    logic                  r_got_data;
    logic                  r_eop;

    logic w_rx, w_start, w_tick, w_centre, w_par_exp;
    logic w_pop, w_full, w_wr, w_ovr, w_idle, w_eop;

    assign w_rx      = r_sync[1];
    assign w_start   = (r_state == S_IDLE) && r_rx_prev && !w_rx;
    assign w_tick    = (r_div_cnt == DIV_W'(DIV - 1));
    // Start bit is checked at half a bit, every later sample one full bit on.
    assign w_centre  = w_tick && (r_tick_cnt == ((r_state == S_START) ?
                       TICK_W'(OVERSAMPLE / 2 - 1) : TICK_W'(OVERSAMPLE - 1)));
    assign w_par_exp = (PARITY == 2) ? ~^r_shift : ^r_shift;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_div_cnt <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_sync    <= {r_sync[0], rxd};
            r_rx_prev <= w_rx;
            if (w_start || w_tick) r_div_cnt <= '0;
            else                   r_div_cnt <= r_div_cnt + 1'b1;
            if (w_start)       r_tick_cnt <= '0;
            else if (w_centre) r_tick_cnt <= '0;
            else if (w_tick)   r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_bad    <= 1'b0;
            r_push       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_push       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_state   <= S_START;
                    r_bit_cnt <= '0;
                    r_par_bad <= 1'b0;
                end
                S_START: if (w_centre) r_state <= w_rx ? S_IDLE : S_DATA;
                S_DATA: if (w_centre) begin
                    r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == BIT_W'(DATA_BITS - 1))
                        r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY: if (w_centre) begin
                    r_par_bad <= w_rx ^ w_par_exp;
                    r_state   <= S_STOP;
                end
                S_STOP: if (w_centre) begin
                    if (w_rx) begin
                        if (r_par_bad) r_parity_err <= 1'b1;
                        else           r_push       <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_BREAK;
                    end
                end
                S_BREAK: if (w_rx) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_pop  = rd_en && (r_count != '0);
    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_wr   = r_push && (!w_full || w_pop);
    assign w_ovr  = r_push && w_full && !w_pop;

    // NOTE: storage array carries no reset; the count gates rd_data instead.
    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_ovr;
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_idle = (r_idle_cnt == IDLE_W'(IDLE_MAX)) && (r_state == S_IDLE);
    assign w_eop  = w_idle && !r_idle_d && r_got_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= '0;
            r_idle_d   <= 1'b0;
            r_got_data <= 1'b0;
            r_eop      <= 1'b0;
        end else begin
            if (!w_rx)
                r_idle_cnt <= '0;
            else if (w_tick && (r_idle_cnt != IDLE_W'(IDLE_MAX)))
                r_idle_cnt <= r_idle_cnt + 1'b1;
            r_idle_d <= w_idle;
            r_eop    <= w_eop;
            if (w_wr)       r_got_data <= 1'b1;
            else if (w_eop) r_got_data <= 1'b0;
        end
    end

    assign rd_data        = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign rd_valid       = (r_count != '0);
    assign fifo_count     = r_count;
    assign overrun        = r_overrun;
    assign frame_err      = r_frame_err;
    assign parity_err     = r_parity_err;
    assign rx_idle        = w_idle;
    assign rx_endofpacket = r_eop;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one instance without parity, one with even parity,
// both at 16 clocks per bit.
module tb_uart_rx_fifo;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd0 = 1'b1, rxd1 = 1'b1;
    logic       rd_en0 = 1'b0, rd_en1 = 1'b0;
    logic [7:0] rd_data0, rd_data1;
    logic       rd_valid0, rd_valid1;
    logic [2:0] count0, count1;
    logic       ovr0, ovr1, fe0, fe1, pe0, pe1, idle0, idle1, eop0, eop1;

    int n_vec = 0;
    int n_err = 0;
    int c_ovr0 = 0, c_fe0 = 0, c_pe0 = 0, c_eop0 = 0, c_pe1 = 0, c_fe1 = 0;

    always #5 clock = ~clock;

    uart_rx_fifo #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(0), .FIFO_DEPTH(4), .IDLE_BITS(4)) dut0 (
        .clock(clock), .reset_n(reset_n), .rxd(rxd0), .rd_en(rd_en0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .fifo_count(count0),
        .overrun(ovr0), .frame_err(fe0), .parity_err(pe0),
        .rx_idle(idle0), .rx_endofpacket(eop0));

    uart_rx_fifo #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(1), .FIFO_DEPTH(4), .IDLE_BITS(4)) dut1 (
        .clock(clock), .reset_n(reset_n), .rxd(rxd1), .rd_en(rd_en1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .fifo_count(count1),
        .overrun(ovr1), .frame_err(fe1), .parity_err(pe1),
        .rx_idle(idle1), .rx_endofpacket(eop1));

    always @(negedge clock) begin
        if (ovr0) c_ovr0 <= c_ovr0 + 1;
        if (fe0)  c_fe0  <= c_fe0 + 1;
        if (pe0)  c_pe0  <= c_pe0 + 1;
        if (eop0) c_eop0 <= c_eop0 + 1;
        if (pe1)  c_pe1  <= c_pe1 + 1;
        if (fe1)  c_fe1  <= c_fe1 + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rxd0 = v;
        else          rxd1 = v;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop);
        drive(sel, 1'b0);
        wait_clks(16);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            wait_clks(16);
        end
        if (has_par) begin
            drive(sel, par);
            wait_clks(16);
        end
        drive(sel, stop);
        wait_clks(16);
    endtask

    task automatic do_reset();
        rxd0 = 1'b1;
        rxd1 = 1'b1;
        rd_en0 = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(3);
    endtask

    task automatic pop0();
        rd_en0 = 1'b1;
        @(negedge clock);
        rd_en0 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (rd_valid0 !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rd_valid0); end
        n_vec++; if (count0 !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count0); end
        n_vec++; if (rd_data0 !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rd_data0); end
        n_vec++; if ({ovr0, fe0, pe0, eop0, idle0} !== 5'b0) begin n_err++; $display("FAIL reset_flags: got %b want 00000", {ovr0, fe0, pe0, eop0, idle0}); end
    endtask

    task automatic test_basic();
        int eop_s;
        do_reset();
        eop_s = c_eop0;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        wait_clks(1);
        n_vec++; if (count0 !== 3'd2) begin n_err++; $display("FAIL basic_count2: got %0d want 2", count0); end
        n_vec++; if (rd_data0 !== 8'hA5) begin n_err++; $display("FAIL basic_head: got %h want a5", rd_data0); end
        n_vec++; if (rd_valid0 !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", rd_valid0); end
        n_vec++; if (idle0 !== 1'b0) begin n_err++; $display("FAIL basic_not_idle: got %b want 0", idle0); end
        pop0();
        n_vec++; if (rd_data0 !== 8'h3C) begin n_err++; $display("FAIL basic_pop_data: got %h want 3c", rd_data0); end
        n_vec++; if (count0 !== 3'd1) begin n_err++; $display("FAIL basic_pop_count: got %0d want 1", count0); end
        wait_clks(64);
        n_vec++; if (idle0 !== 1'b1) begin n_err++; $display("FAIL basic_idle: got %b want 1", idle0); end
        wait_clks(100);
        n_vec++; if (c_eop0 - eop_s !== 1) begin n_err++; $display("FAIL basic_eop: got %0d pulses want 1", c_eop0 - eop_s); end
    endtask

    task automatic test_glitch();
        int fe_s, pe_s;
        do_reset();
        fe_s = c_fe0;
        pe_s = c_pe0;
        rxd0 = 1'b0;
        wait_clks(4);
        rxd0 = 1'b1;
        wait_clks(40);
        n_vec++; if (count0 !== 3'd0) begin n_err++; $display("FAIL glitch_count: got %0d want 0", count0); end
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        wait_clks(2);
        n_vec++; if (count0 !== 3'd1) begin n_err++; $display("FAIL glitch_next_count: got %0d want 1", count0); end
        n_vec++; if (rd_data0 !== 8'h5A) begin n_err++; $display("FAIL glitch_next_data: got %h want 5a", rd_data0); end
        n_vec++; if ((c_fe0 - fe_s) + (c_pe0 - pe_s) !== 0) begin n_err++; $display("FAIL glitch_flags: got %0d error pulses want 0", (c_fe0 - fe_s) + (c_pe0 - pe_s)); end
    endtask

    task automatic test_parity();
        int pe_s, fe_s;
        do_reset();
        pe_s = c_pe1;
        fe_s = c_fe1;
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        wait_clks(4);
        n_vec++; if (c_pe1 - pe_s !== 1) begin n_err++; $display("FAIL parity_bad_pulse: got %0d want 1", c_pe1 - pe_s); end
        n_vec++; if (count1 !== 3'd0) begin n_err++; $display("FAIL parity_bad_count: got %0d want 0", count1); end
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        wait_clks(4);
        n_vec++; if (count1 !== 3'd1) begin n_err++; $display("FAIL parity_good_count: got %0d want 1", count1); end
        n_vec++; if (rd_data1 !== 8'h07) begin n_err++; $display("FAIL parity_good_data: got %h want 07", rd_data1); end
        n_vec++; if ((c_pe1 - pe_s) + (c_fe1 - fe_s) !== 1) begin n_err++; $display("FAIL parity_total: got %0d error pulses want 1", (c_pe1 - pe_s) + (c_fe1 - fe_s)); end
    endtask

    task automatic test_break();
        int fe_s;
        do_reset();
        fe_s = c_fe0;
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        wait_clks(320);
        n_vec++; if (c_fe0 - fe_s !== 1) begin n_err++; $display("FAIL break_mid_fe: got %0d want 1", c_fe0 - fe_s); end
        n_vec++; if (count0 !== 3'd0) begin n_err++; $display("FAIL break_mid_count: got %0d want 0", count0); end
        wait_clks(320);
        rxd0 = 1'b1;
        wait_clks(32);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        wait_clks(2);
        n_vec++; if (c_fe0 - fe_s !== 1) begin n_err++; $display("FAIL break_fe_total: got %0d want 1", c_fe0 - fe_s); end
        n_vec++; if (count0 !== 3'd1) begin n_err++; $display("FAIL break_count: got %0d want 1", count0); end
        n_vec++; if (rd_data0 !== 8'h12) begin n_err++; $display("FAIL break_data: got %h want 12", rd_data0); end
    endtask

    task automatic test_overrun();
        int ovr_s;
        logic [7:0] exp_b;
        do_reset();
        ovr_s = c_ovr0;
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
        wait_clks(2);
        n_vec++; if (count0 !== 3'd4) begin n_err++; $display("FAIL ovr_count: got %0d want 4", count0); end
        n_vec++; if (c_ovr0 - ovr_s !== 1) begin n_err++; $display("FAIL ovr_pulse: got %0d want 1", c_ovr0 - ovr_s); end
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            n_vec++; if (rd_data0 !== exp_b) begin n_err++; $display("FAIL ovr_readout%0d: got %h want %h", i, rd_data0, exp_b); end
            pop0();
        end
        n_vec++; if (rd_valid0 !== 1'b0) begin n_err++; $display("FAIL ovr_drained: got %b want 0", rd_valid0); end
        ovr_s = c_ovr0;
        for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
        // Start bit driven at negedge n0; stop sample lands on posedge 155, push on 156.
        fork
            send_frame(0, 8'h05, 1'b0, 1'b0, 1'b1);
            begin
                wait_clks(155);
                rd_en0 = 1'b1;
                @(negedge clock);
                rd_en0 = 1'b0;
            end
        join
        wait_clks(2);
        n_vec++; if (count0 !== 3'd4) begin n_err++; $display("FAIL ovr_pp_count: got %0d want 4", count0); end
        n_vec++; if (c_ovr0 - ovr_s !== 0) begin n_err++; $display("FAIL ovr_pp_pulse: got %0d want 0", c_ovr0 - ovr_s); end
        n_vec++; if (rd_data0 !== 8'h02) begin n_err++; $display("FAIL ovr_pp_head: got %h want 02", rd_data0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        n_vec++; if (count0 !== 3'd2) begin n_err++; $display("FAIL rmid_pre_count: got %0d want 2", count0); end
        rxd0 = 1'b0;
        wait_clks(16);
        rxd0 = 1'b1;
        wait_clks(48);
        reset_n = 1'b0;
        #1;
        n_vec++; if (count0 !== 3'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", count0); end
        n_vec++; if ({rd_valid0, rd_data0} !== 9'h000) begin n_err++; $display("FAIL rmid_data: got %b/%h want 0/00", rd_valid0, rd_data0); end
        n_vec++; if ({ovr0, fe0, pe0, eop0, idle0} !== 5'b0) begin n_err++; $display("FAIL rmid_flags: got %b want 00000", {ovr0, fe0, pe0, eop0, idle0}); end
        wait_clks(5);
        reset_n = 1'b1;
        wait_clks(5);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        wait_clks(2);
        n_vec++; if (count0 !== 3'd1) begin n_err++; $display("FAIL rmid_after_count: got %0d want 1", count0); end
        n_vec++; if (rd_data0 !== 8'h81) begin n_err++; $display("FAIL rmid_after_data: got %h want 81", rd_data0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_break();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receive channel: the next generation of the board's async serial receiver. It adds configurable data width, parity and oversampling, a line-glitch filter, error reporting and a first-word-fall-through receive FIFO, so the game logic can drain bytes at its own pace. It sits between the board RxD pin and the Battleship protocol/command decoder, and keeps the idle and end-of-packet indications of the existing receiver.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 16, sample ticks per bit; even, >=8
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = even, 2 = odd
FIFO_DEPTH, 16, receive FIFO entries; power of two, >=2
IDLE_BITS, 16, line-high bit times before rx_idle asserts

Ports:
clock  in  1  system clock, all logic on its rising edge
reset_n  in  1  asynchronous active-low reset
rxd  in  1  raw serial line, asynchronous to clock
rd_en  in  1  pop the FIFO head when rd_valid=1
rd_data  out  DATA_BITS  FIFO head, valid while rd_valid=1
rd_valid  out  1  FIFO not empty
fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries
overrun  out  1  1-cycle pulse: good frame dropped, FIFO full
frame_err  out  1  1-cycle pulse: stop bit sampled 0
parity_err  out  1  1-cycle pulse: parity mismatch
rx_idle  out  1  line idle for IDLE_BITS bit times
rx_endofpacket  out  1  1-cycle pulse at idle after >=1 received byte

Behaviour:
- Reset (async assert, sync deassert handled externally): the rxd synchroniser resets to 1, FSM = IDLE, FIFO is empty. Outputs: rd_valid=0, fifo_count=0, rd_data=0, all pulses=0, rx_idle=0.
- rxd passes through a 2-flop synchroniser. All decisions use the synchronised value, which adds 2 cycles of latency.
- Tick generator: DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)), minimum 1. It issues a one-cycle tick every DIV clocks and free-runs, except that it restarts on start-edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE -> START on a synchronised falling edge. The tick counter is cleared.
- START: at tick OVERSAMPLE/2 the line is re-sampled. If it reads 1, the event is a glitch: return to IDLE with no flags. If it reads 0, go to DATA.
- DATA: sample every OVERSAMPLE ticks (bit centre) and shift in LSB first. After DATA_BITS samples, go to PARITY if PARITY!=0, otherwise to STOP.
- PARITY: sample one bit and compare it against the even/odd parity of the data bits.
- STOP: sample at bit centre.
  - Sample 1 with no parity error: push the word and return to IDLE.
  - Sample 1 with a parity error: pulse parity_err, drop the word, return to IDLE.
  - Sample 0: pulse frame_err, drop the word, go to BREAK.
- BREAK -> IDLE once the synchronised line reads 1. No new start is detected while in BREAK.
- Frame_err and parity_err both set: only frame_err pulses.
- Push/pop rules:
  - A push occurs in the cycle after the stop-bit sample.
  - When the FIFO is full and there is no pop in the same cycle, the push is dropped and overrun pulses.
  - A simultaneous push and pop when full is legal: count is unchanged and there is no overrun.
  - A simultaneous push and pop when empty: rd_valid rises next cycle carrying the pushed word; the pop is ignored.
  - rd_en while rd_valid=0 is ignored.
- FIFO is first-word-fall-through. rd_data is updated the cycle after a pop. Pointers wrap modulo FIFO_DEPTH. fifo_count is exact at every cycle.
- Idle detection:
  - A counter of ticks with the line high clears on any low sample, and saturates at IDLE_BITS*OVERSAMPLE ticks.
  - rx_idle = 1 while the counter is saturated and the FSM is in IDLE.
  - A got_data flag sets on each successful push and clears when rx_endofpacket fires.
  - rx_endofpacket pulses one cycle on the rising edge of rx_idle when got_data=1.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ=1600000, BAUD=100000, OVERSAMPLE=16 (DIV=1, 16 clocks/bit), DATA_BITS=8, FIFO_DEPTH=4, IDLE_BITS=4.
- PARITY=0; send 0xA5 then 0x3C with rd_en=0 -> fifo_count=2, rd_data=0xA5. Pulse rd_en -> rd_data=0x3C, count=1. After 64 high bit-clocks: rx_idle=1 and one rx_endofpacket pulse.
- Drive rxd low for 4 clocks, then high -> FSM returns to IDLE, no flags, fifo_count=0.
- PARITY=1; send 0x07 with parity bit 0 (wrong) -> parity_err pulses once, count=0. Resend with parity bit 1 -> count=1, rd_data=0x07.
- Send 0x55 with stop bit 0, hold line low 40 bit times, then send 0x12 -> one frame_err pulse, only 0x12 is stored. No start is detected during the low period.
- Send 5 bytes 0x01..0x05 with rd_en=0 -> count=4, overrun pulses on the 5th byte, readout is 0x01..0x04. Repeat with rd_en held high on the 5th push cycle -> no overrun, count=4.
- Assert reset_n=0 mid-DATA of 0xFF with count=2 -> all outputs return to reset values immediately. After release, a clean 0x81 is received correctly.
